sevenseg_scan_driver: RTL and testbench

//  Parametrised multiplexed seven-segment display driver: latches an N-digit hex value and time-multiplexes it onto one

---
 rtl/sevenseg_scan_driver.sv | 207 ++++++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Multiplexed N-digit hex seven-segment driver. It latches a hex value
//   (plus per-digit decimal points, blanking and leading-zero control) into
//   a shadow copy, then scans the digits onto one shared segment bus with
//   one-hot digit enables. It optionally defers new values to the frame
//   boundary so a refresh never shows a half-old, half-new value.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   load       1-cycle strobe, captures data/dp/blank/lz_en
//   data       hex nibbles, digit 0 = data[3:0] (rightmost)
//   dp         decimal point per digit
//   blank      1: whole display dark
//   lz_en      1: suppress leading zeros
//   seg        segments, seg[0]=a .. seg[6]=g (polarity per SEG_ACT_LOW)
//   seg_dp     decimal point of the active digit (polarity per SEG_ACT_LOW)
//   an         one-hot digit enable (polarity per AN_ACT_LOW)
//   digit_idx  index of the digit currently being driven
//   frame_tick 1-cycle pulse when the scan wraps N_DIGITS-1 -> 0
//   pending    a captured load is waiting for the frame boundary
module sevenseg_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int SEG_ACT_LOW = 0,
    parameter int AN_ACT_LOW  = 0,
    parameter int SYNC_UPDATE = 1,
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic                  blank,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int   PRE_W   = $clog2(REFRESH_DIV);
    localparam logic SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic AN_INV  = (AN_ACT_LOW != 0);

    logic [PRE_W-1:0]      prescale;
    logic                  tc;
    logic                  wrap;

    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  shadow_blank;
    logic                  shadow_lz;

    logic [4*N_DIGITS-1:0] hold_data;
    logic [N_DIGITS-1:0]   hold_dp;
    logic                  hold_blank;
    logic                  hold_lz;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_supp;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  seen_nz;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [N_DIGITS-1:0]   an_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tc   = (prescale == PRE_W'(REFRESH_DIV - 1));
    assign wrap = tc && (digit_idx == IDX_W'(N_DIGITS - 1));

    // A digit is a leading zero when it and every digit above it are zero.
    // Digit 0 is never suppressed, so a value of zero still shows "0".
    always_comb begin
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            seen_nz    = seen_nz | (shadow_data[4*i +: 4] != 4'h0);
            lz_mask[i] = ~seen_nz;
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib  = shadow_data[4*i +: 4];
                cur_dp   = shadow_dp[i];
                cur_supp = shadow_lz & lz_mask[i];
            end
        end
    end

    always_comb begin
        seg_nxt = '0;
        dp_nxt  = 1'b0;
        an_nxt  = '0;
        if (!shadow_blank) begin
            seg_nxt = cur_supp ? 7'h00 : hex_to_seg(cur_nib);
            dp_nxt  = cur_dp;
            an_nxt  = {{(N_DIGITS-1){1'b0}}, 1'b1} << digit_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale   <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (tc) begin
                prescale  <= '0;
                digit_idx <= wrap ? '0 : digit_idx + IDX_W'(1);
            end else begin
                prescale  <= prescale + PRE_W'(1);
            end
        end
    end

    // In deferred mode a load parks in the hold buffer and is copied to the
    // shadow at the wrap edge. A load arriving on the wrap edge itself goes
    // straight to the shadow and supersedes anything parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= 1'b1;
            shadow_lz    <= 1'b0;
            hold_data    <= '0;
            hold_dp      <= '0;
            hold_blank   <= 1'b1;
            hold_lz      <= 1'b0;
            pending      <= 1'b0;
        end else if (SYNC_UPDATE == 0) begin
            pending <= 1'b0;
            if (load) begin
                shadow_data  <= data;
                shadow_dp    <= dp;
                shadow_blank <= blank;
                shadow_lz    <= lz_en;
            end
        end else begin
            if (wrap) begin
                pending <= 1'b0;
                if (load) begin
                    shadow_data  <= data;
                    shadow_dp    <= dp;
                    shadow_blank <= blank;
                    shadow_lz    <= lz_en;
                end else if (pending) begin
                    shadow_data  <= hold_data;
                    shadow_dp    <= hold_dp;
                    shadow_blank <= hold_blank;
                    shadow_lz    <= hold_lz;
                end
            end else if (load) begin
                hold_data  <= data;
                hold_dp    <= dp;
                hold_blank <= blank;
                hold_lz    <= lz_en;
                pending    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg    <= {7{SEG_INV}};
            seg_dp <= SEG_INV;
            an     <= {N_DIGITS{AN_INV}};
        end else begin
            seg    <= seg_nxt ^ {7{SEG_INV}};
            seg_dp <= dp_nxt ^ SEG_INV;
            an     <= an_nxt ^ {N_DIGITS{AN_INV}};
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
module tb_sevenseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_a = 1'b0;
    logic        load_s = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic        blank = 1'b0;
    logic        lz_en = 1'b0;

    logic [6:0] seg_a, seg_i, seg_s;
    logic       dp_a, dp_i, dp_s;
    logic [3:0] an_a, an_i, an_s;
    logic [1:0] idx_a, idx_i, idx_s;
    logic       ft_a, ft_i, ft_s;
    logic       pend_a, pend_i, pend_s;

    int checks = 0;
    int errors = 0;
    int cnt;   // posedges since reset release: the bench's own scan model

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else     cnt <= cnt + 1;
    end

    sevenseg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .SEG_ACT_LOW(0), .AN_ACT_LOW(0), .SYNC_UPDATE(0)) dut_a (
        .clk(clk), .rst(rst), .load(load_a), .data(data), .dp(dp), .blank(blank), .lz_en(lz_en),
        .seg(seg_a), .seg_dp(dp_a), .an(an_a), .digit_idx(idx_a), .frame_tick(ft_a), .pending(pend_a));

    sevenseg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .SEG_ACT_LOW(1), .AN_ACT_LOW(1), .SYNC_UPDATE(0)) dut_i (
        .clk(clk), .rst(rst), .load(load_a), .data(data), .dp(dp), .blank(blank), .lz_en(lz_en),
        .seg(seg_i), .seg_dp(dp_i), .an(an_i), .digit_idx(idx_i), .frame_tick(ft_i), .pending(pend_i));

    sevenseg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .SEG_ACT_LOW(0), .AN_ACT_LOW(0), .SYNC_UPDATE(1)) dut_s (
        .clk(clk), .rst(rst), .load(load_s), .data(data), .dp(dp), .blank(blank), .lz_en(lz_en),
        .seg(seg_s), .seg_dp(dp_s), .an(an_s), .digit_idx(idx_s), .frame_tick(ft_s), .pending(pend_s));

    task automatic test_reset();
        logic [1:0] e_idx;
        logic       e_ft;
        repeat (3) @(negedge clk);
        checks++; if (seg_a !== 7'h00) begin errors++; $display("FAIL rst_seg got %h exp 00", seg_a); end
        checks++; if (an_a !== 4'h0) begin errors++; $display("FAIL rst_an got %h exp 0", an_a); end
        checks++; if (dp_a !== 1'b0) begin errors++; $display("FAIL rst_dp got %b exp 0", dp_a); end
        checks++; if (idx_a !== 2'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", idx_a); end
        checks++; if (ft_a !== 1'b0) begin errors++; $display("FAIL rst_ft got %b exp 0", ft_a); end
        checks++; if (pend_s !== 1'b0) begin errors++; $display("FAIL rst_pend got %b exp 0", pend_s); end
        checks++; if (seg_i !== 7'h7F) begin errors++; $display("FAIL rst_seg_inv got %h exp 7f", seg_i); end
        checks++; if (an_i !== 4'hF) begin errors++; $display("FAIL rst_an_inv got %h exp f", an_i); end
        checks++; if (dp_i !== 1'b1) begin errors++; $display("FAIL rst_dp_inv got %b exp 1", dp_i); end
        rst = 1'b0;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            e_idx = 2'((cnt >> 2) & 3);
            e_ft  = (cnt != 0) && (cnt % 16 == 0);
            checks++; if (idx_a !== e_idx) begin errors++; $display("FAIL scan_idx cnt=%0d got %0d exp %0d", cnt, idx_a, e_idx); end
            checks++; if (idx_i !== e_idx) begin errors++; $display("FAIL scan_idx_inv cnt=%0d got %0d exp %0d", cnt, idx_i, e_idx); end
            checks++; if (idx_s !== e_idx) begin errors++; $display("FAIL scan_idx_sync cnt=%0d got %0d exp %0d", cnt, idx_s, e_idx); end
            checks++; if (ft_a !== e_ft) begin errors++; $display("FAIL frame_tick cnt=%0d got %b exp %b", cnt, ft_a, e_ft); end
            checks++; if (ft_s !== e_ft) begin errors++; $display("FAIL frame_tick_sync cnt=%0d got %b exp %b", cnt, ft_s, e_ft); end
            checks++; if (an_a !== 4'h0 || seg_a !== 7'h00) begin errors++; $display("FAIL dark_after_rst cnt=%0d got an=%h seg=%h exp 0/00", cnt, an_a, seg_a); end
            checks++; if (an_i !== 4'hF) begin errors++; $display("FAIL dark_inv cnt=%0d got %h exp f", cnt, an_i); end
        end
    endtask

    task automatic test_decode();
        logic [6:0] e_tab [4];
        logic [3:0] e_an;
        int i;
        e_tab[0] = 7'h71; e_tab[1] = 7'h77; e_tab[2] = 7'h5B; e_tab[3] = 7'h06;
        @(negedge clk);
        data = 16'h12AF; dp = 4'b0100; blank = 1'b0; lz_en = 1'b0; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        checks++; if (an_a !== 4'h0) begin errors++; $display("FAIL decode_latency got an=%h exp 0", an_a); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            i = ((cnt - 1) >> 2) & 3;
            e_an = 4'b0001 << i;
            checks++; if (an_a !== e_an) begin errors++; $display("FAIL decode_an d=%0d got %h exp %h", i, an_a, e_an); end
            checks++; if (seg_a !== e_tab[i]) begin errors++; $display("FAIL decode_seg d=%0d got %h exp %h", i, seg_a, e_tab[i]); end
            checks++; if (dp_a !== dp[i]) begin errors++; $display("FAIL decode_dp d=%0d got %b exp %b", i, dp_a, dp[i]); end
            checks++; if (an_i !== ~e_an) begin errors++; $display("FAIL inv_an d=%0d got %h exp %h", i, an_i, ~e_an); end
            checks++; if (seg_i !== ~e_tab[i]) begin errors++; $display("FAIL inv_seg d=%0d got %h exp %h", i, seg_i, ~e_tab[i]); end
            checks++; if (dp_i !== ~dp[i]) begin errors++; $display("FAIL inv_dp d=%0d got %b exp %b", i, dp_i, ~dp[i]); end
            checks++; if (pend_a !== 1'b0 || pend_i !== 1'b0) begin errors++; $display("FAIL async_pending got %b%b exp 00", pend_a, pend_i); end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] e_tab [4];
        logic [3:0] e_an;
        int i;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                data = 16'h0050; dp = 4'b1000;
                e_tab[0] = 7'h3F; e_tab[1] = 7'h6D; e_tab[2] = 7'h00; e_tab[3] = 7'h00;
            end else begin
                data = 16'h0000; dp = 4'b0000;
                e_tab[0] = 7'h3F; e_tab[1] = 7'h00; e_tab[2] = 7'h00; e_tab[3] = 7'h00;
            end
            lz_en = 1'b1; blank = 1'b0; load_a = 1'b1;
            @(negedge clk);
            load_a = 1'b0;
            for (int k = 0; k < 17; k++) begin
                @(negedge clk);
                i = ((cnt - 1) >> 2) & 3;
                e_an = 4'b0001 << i;
                checks++; if (an_a !== e_an) begin errors++; $display("FAIL lz_an case=%0d d=%0d got %h exp %h", c, i, an_a, e_an); end
                checks++; if (seg_a !== e_tab[i]) begin errors++; $display("FAIL lz_seg case=%0d d=%0d got %h exp %h", c, i, seg_a, e_tab[i]); end
                checks++; if (dp_a !== dp[i]) begin errors++; $display("FAIL lz_dp case=%0d d=%0d got %b exp %b", c, i, dp_a, dp[i]); end
            end
        end
    endtask

    task automatic test_blank();
        data = 16'h8888; dp = 4'hF; lz_en = 1'b0; blank = 1'b1; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (an_a !== 4'h0 || seg_a !== 7'h00 || dp_a !== 1'b0) begin errors++; $display("FAIL blank_dark got an=%h seg=%h dp=%b exp 0/00/0", an_a, seg_a, dp_a); end
            checks++; if (an_i !== 4'hF || seg_i !== 7'h7F || dp_i !== 1'b1) begin errors++; $display("FAIL blank_dark_inv got an=%h seg=%h dp=%b exp f/7f/1", an_i, seg_i, dp_i); end
            checks++; if (idx_a !== 2'((cnt >> 2) & 3)) begin errors++; $display("FAIL blank_scan got %0d exp %0d", idx_a, (cnt >> 2) & 3); end
        end
        blank = 1'b0; dp = 4'h0;
    endtask

    task automatic test_sync_update();
        logic [6:0] old_tab [4];
        logic [6:0] new_tab [4];
        logic       old_dark;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        int i, w, c;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                old_dark = 1'b1;
                old_tab[0] = 7'h00; old_tab[1] = 7'h00; old_tab[2] = 7'h00; old_tab[3] = 7'h00;
                new_tab[0] = 7'h66; new_tab[1] = 7'h4F; new_tab[2] = 7'h5B; new_tab[3] = 7'h06;
            end else begin
                old_dark = 1'b0;
                old_tab[0] = 7'h66; old_tab[1] = 7'h4F; old_tab[2] = 7'h5B; old_tab[3] = 7'h06;
                new_tab[0] = 7'h7F; new_tab[1] = 7'h07; new_tab[2] = 7'h7D; new_tab[3] = 7'h6D;
            end
            for (int k = 0; k < 16 && (cnt % 16) != 6; k++) @(negedge clk);
            data = (s == 0) ? 16'h1234 : 16'h5678; dp = 4'h0; blank = 1'b0; lz_en = 1'b0;
            load_s = 1'b1;
            @(negedge clk);
            load_s = 1'b0;
            w = cnt - 7 + 16;
            for (int k = 0; k < 24; k++) begin
                c = cnt;
                i = ((c - 1) >> 2) & 3;
                if (c <= w && old_dark) begin
                    e_an = 4'h0; e_seg = 7'h00;
                end else begin
                    e_an = 4'b0001 << i; e_seg = (c > w) ? new_tab[i] : old_tab[i];
                end
                checks++; if (pend_s !== (c < w)) begin errors++; $display("FAIL sync_pending s=%0d cnt=%0d got %b exp %b", s, c, pend_s, c < w); end
                checks++; if (ft_s !== (c == w)) begin errors++; $display("FAIL sync_tick s=%0d cnt=%0d got %b exp %b", s, c, ft_s, c == w); end
                checks++; if (an_s !== e_an) begin errors++; $display("FAIL sync_an s=%0d cnt=%0d got %h exp %h", s, c, an_s, e_an); end
                checks++; if (seg_s !== e_seg) begin errors++; $display("FAIL sync_seg s=%0d cnt=%0d got %h exp %h", s, c, seg_s, e_seg); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] old_tab [4];
        logic [6:0] e_seg;
        logic [3:0] e_an;
        int i, w, c;
        old_tab[0] = 7'h7F; old_tab[1] = 7'h07; old_tab[2] = 7'h7D; old_tab[3] = 7'h6D;
        for (int k = 0; k < 16 && (cnt % 16) != 3; k++) @(negedge clk);
        w = cnt - 3 + 16;
        data = 16'h1111; load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
        for (int k = 0; k < 16 && (cnt % 16) != 9; k++) @(negedge clk);
        data = 16'h2222; load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
        for (int k = 0; k < 17; k++) begin
            c = cnt;
            i = ((c - 1) >> 2) & 3;
            e_an = 4'b0001 << i;
            e_seg = (c > w) ? 7'h5B : old_tab[i];
            checks++; if (pend_s !== (c < w)) begin errors++; $display("FAIL b2b_pending cnt=%0d got %b exp %b", c, pend_s, c < w); end
            checks++; if (an_s !== e_an) begin errors++; $display("FAIL b2b_an cnt=%0d got %h exp %h", c, an_s, e_an); end
            checks++; if (seg_s !== e_seg) begin errors++; $display("FAIL b2b_seg cnt=%0d got %h exp %h", c, seg_s, e_seg); end
            @(negedge clk);
        end
        for (int k = 0; k < 16 && (cnt % 16) != 15; k++) @(negedge clk);
        data = 16'h9999; load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
        checks++; if (pend_s !== 1'b0) begin errors++; $display("FAIL wrap_load_pending got %b exp 0", pend_s); end
        checks++; if (ft_s !== 1'b1) begin errors++; $display("FAIL wrap_load_tick got %b exp 1", ft_s); end
        checks++; if (seg_s !== 7'h5B) begin errors++; $display("FAIL wrap_load_old got %h exp 5b", seg_s); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            i = ((cnt - 1) >> 2) & 3;
            e_an = 4'b0001 << i;
            checks++; if (pend_s !== 1'b0) begin errors++; $display("FAIL wrap_load_nopend got %b exp 0", pend_s); end
            checks++; if (an_s !== e_an || seg_s !== 7'h6F) begin errors++; $display("FAIL wrap_load_new got an=%h seg=%h exp %h/6f", an_s, seg_s, e_an); end
        end
    endtask

    task automatic test_reset_mid_pending();
        for (int k = 0; k < 16 && (cnt % 16) != 2; k++) @(negedge clk);
        data = 16'h4444; load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
        for (int k = 0; k < 16 && (cnt % 16) != 9; k++) @(negedge clk);
        checks++; if (pend_s !== 1'b1) begin errors++; $display("FAIL midrst_pend_before got %b exp 1", pend_s); end
        checks++; if (idx_s !== 2'd2) begin errors++; $display("FAIL midrst_idx_before got %0d exp 2", idx_s); end
        rst = 1'b1;
        #1;
        checks++; if (an_s !== 4'h0 || seg_s !== 7'h00 || dp_s !== 1'b0) begin errors++; $display("FAIL midrst_dark got an=%h seg=%h dp=%b exp 0/00/0", an_s, seg_s, dp_s); end
        checks++; if (pend_s !== 1'b0) begin errors++; $display("FAIL midrst_pend got %b exp 0", pend_s); end
        checks++; if (idx_s !== 2'd0) begin errors++; $display("FAIL midrst_idx got %0d exp 0", idx_s); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            checks++; if (an_s !== 4'h0 || seg_s !== 7'h00) begin errors++; $display("FAIL midrst_discard cnt=%0d got an=%h seg=%h exp 0/00", cnt, an_s, seg_s); end
            checks++; if (pend_s !== 1'b0) begin errors++; $display("FAIL midrst_nopend cnt=%0d got %b exp 0", cnt, pend_s); end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_leading_zero();
        test_blank();
        test_sync_update();
        test_back_to_back();
        test_reset_mid_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached without completing the sequence");
        $fatal(1);
    end

endmodule
